// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory bus, redirect input and decode-side handshake of the fetch stage.
// The master modport is the fetch unit's view; the slave modport is the memory/decode/branch side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-indexed PC, single outstanding imem request, prefetch FIFO
// feeding decode, and branch/jump redirect that flushes the buffer and restarts fetching.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_n;
    logic          req_q, req_n;
    logic [31:0]   addr_q, addr_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   count_after;
    logic          ack, pop, push, flush;

    assign ack         = req_q & bus.imem_ack;
    assign pop         = (count != '0) & bus.inst_ready;
    assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    // Redirect overrides everything; an in-flight request that cannot be withdrawn is
    // parked in DROP so its data is thrown away when it finally arrives.
    always_comb begin
        state_n    = state;
        req_n      = req_q;
        addr_n     = addr_q;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect) begin
            flush      = 1'b1;
            fetch_pc_n = bus.redirect_pc;
            if (state == IDLE || ack) begin
                req_n   = 1'b1;
                addr_n  = bus.redirect_pc;
                state_n = WAIT;
            end else begin
                state_n = DROP;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        req_n   = 1'b1;
                        addr_n  = fetch_pc;
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        push       = 1'b1;
                        fetch_pc_n = addr_q + 32'd1;
                        if (count_after < (CW+1)'(DEPTH)) begin
                            addr_n = addr_q + 32'd1;
                        end else begin
                            req_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (ack) begin
                        addr_n  = fetch_pc;
                        state_n = WAIT;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            addr_q   <= addr_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    // A pop on the redirect cycle still counts as delivered; the flush simply empties what remains.
    always_ff @(posedge clk) begin
        if (rst || (flush && !rst)) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]   <= addr_q;
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_out   = mem_inst[rd_ptr];
    assign bus.inst_pc    = mem_pc[rd_ptr];
endmodule
